int_seq: RTL and testbench

//  Execute-stage interrupt sequencer. Consumes the INT flag that leaves the decode->ALU pipeline buffer.
//  On an interrupt it freezes the pipeline and pushes the 32-bit return PC and the 3-bit CCR flags onto the stack.
//  It then reads a 32-bit handler address from the vector table, redirects fetch to it, and hands the updated SP back.

---
 rtl/int_seq.sv | 225 ++++++++++++++++++++++
 tb/tb_int_seq.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/int_seq.sv
// -----------------------------------------------------------------------------
// int_seq -- execute-stage interrupt sequencer
//
// Watches the INT flag leaving the decode->ALU pipeline buffer. On a rising
// edge of that flag (seen while idle) it freezes the pipeline, pushes the
// return PC (high word, then low word) and the CCR flags onto the stack, reads
// the two-word handler address from the vector table, and then, in a single
// LOAD cycle, redirects the PC, writes back the decremented SP and clears CCR.
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous reset, active-high
//   i_int        INT level from the decode->ALU buffer
//   i_pc         return PC accompanying i_int
//   i_flags      current CCR {C,N,Z}
//   i_sp         current stack pointer
//   o_mem_req    memory request valid
//   o_mem_we     1 = write, 0 = read (valid with o_mem_req)
//   o_mem_addr   memory word address
//   o_mem_wdata  write data
//   i_mem_rdata  read data, valid in the cycle i_mem_ack is high for a read
//   i_mem_ack    request accepted/completed this cycle
//   o_stall      freeze fetch/decode and buffer enables
//   o_sp_wr      one-cycle pulse: load o_sp_next into SP
//   o_sp_next    final SP value (i_sp - 3, wrapping)
//   o_pc_load    one-cycle pulse: load o_pc_value into PC
//   o_pc_value   handler address {vec_hi, vec_lo}
//   o_flags_clr  one-cycle pulse: clear CCR (same cycle as o_pc_load)
//
// All outputs are decoded only from registered state, so there is no
// combinational path from any input to any output.
// -----------------------------------------------------------------------------
module int_seq #(
  parameter int                PC_W     = 32,
  parameter int                DATA_W   = 16,
  parameter logic [PC_W-1:0]   VEC_ADDR = 32'h0000_0002
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_int,
  input  logic [PC_W-1:0]   i_pc,
  input  logic [2:0]        i_flags,
  input  logic [PC_W-1:0]   i_sp,
  output logic              o_mem_req,
  output logic              o_mem_we,
  output logic [PC_W-1:0]   o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic [DATA_W-1:0] i_mem_rdata,
  input  logic              i_mem_ack,
  output logic              o_stall,
  output logic              o_sp_wr,
  output logic [PC_W-1:0]   o_sp_next,
  output logic              o_pc_load,
  output logic [PC_W-1:0]   o_pc_value,
  output logic              o_flags_clr
);

  // One stack slot per push; the SP arithmetic wraps naturally at PC_W bits.
  localparam logic [PC_W-1:0]   SP_STEP     = {{(PC_W-1){1'b0}}, 1'b1};
  localparam logic [PC_W-1:0]   VEC_ADDR_LO = VEC_ADDR + SP_STEP;
  localparam logic [PC_W-1:0]   ADDR_ZERO   = {PC_W{1'b0}};
  localparam logic [DATA_W-1:0] DATA_ZERO   = {DATA_W{1'b0}};

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_PUSH_HI  = 3'd1,
    S_PUSH_LO  = 3'd2,
    S_PUSH_FLG = 3'd3,
    S_RD_HI    = 3'd4,
    S_RD_LO    = 3'd5,
    S_LOAD     = 3'd6
  } state_t;

  state_t            state_q, state_d;
  logic              int_q;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [2:0]        flg_q, flg_d;
  logic [PC_W-1:0]   sp_q, sp_d;
  logic [DATA_W-1:0] vec_hi_q, vec_hi_d;
  logic [DATA_W-1:0] vec_lo_q, vec_lo_d;
  logic              trig;

  // Only a low->high transition starts a sequence, so a level held high by
  // the frozen pipeline buffer cannot re-trigger once we return to IDLE.
  assign trig = i_int & ~int_q;

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      int_q    <= 1'b0;
      pc_q     <= ADDR_ZERO;
      flg_q    <= 3'b000;
      sp_q     <= ADDR_ZERO;
      vec_hi_q <= DATA_ZERO;
      vec_lo_q <= DATA_ZERO;
    end else begin
      state_q  <= state_d;
      int_q    <= i_int;
      pc_q     <= pc_d;
      flg_q    <= flg_d;
      sp_q     <= sp_d;
      vec_hi_q <= vec_hi_d;
      vec_lo_q <= vec_lo_d;
    end
  end

  // Next-state, datapath updates and Moore output decode.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    flg_d       = flg_q;
    sp_d        = sp_q;
    vec_hi_d    = vec_hi_q;
    vec_lo_d    = vec_lo_q;
    o_mem_req   = 1'b0;
    o_mem_we    = 1'b0;
    o_mem_addr  = ADDR_ZERO;
    o_mem_wdata = DATA_ZERO;
    o_stall     = 1'b0;
    o_sp_wr     = 1'b0;
    o_sp_next   = ADDR_ZERO;
    o_pc_load   = 1'b0;
    o_pc_value  = ADDR_ZERO;
    o_flags_clr = 1'b0;

    case (state_q)
      S_IDLE: begin
        // Edges arriving while busy are deliberately not remembered.
        if (trig) begin
          pc_d    = i_pc;
          flg_d   = i_flags;
          sp_d    = i_sp;
          state_d = S_PUSH_HI;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_PUSH_HI: begin
        o_stall     = 1'b1;
        o_mem_req   = 1'b1;
        o_mem_we    = 1'b1;
        o_mem_addr  = sp_q;
        o_mem_wdata = pc_q[PC_W-1 -: DATA_W];
        if (i_mem_ack) begin
          sp_d    = sp_q - SP_STEP;
          state_d = S_PUSH_LO;
        end else begin
          state_d = S_PUSH_HI;
        end
      end

      S_PUSH_LO: begin
        o_stall     = 1'b1;
        o_mem_req   = 1'b1;
        o_mem_we    = 1'b1;
        o_mem_addr  = sp_q;
        o_mem_wdata = pc_q[DATA_W-1:0];
        if (i_mem_ack) begin
          sp_d    = sp_q - SP_STEP;
          state_d = S_PUSH_FLG;
        end else begin
          state_d = S_PUSH_LO;
        end
      end

      S_PUSH_FLG: begin
        o_stall     = 1'b1;
        o_mem_req   = 1'b1;
        o_mem_we    = 1'b1;
        o_mem_addr  = sp_q;
        o_mem_wdata = {{(DATA_W-3){1'b0}}, flg_q};
        if (i_mem_ack) begin
          sp_d    = sp_q - SP_STEP;
          state_d = S_RD_HI;
        end else begin
          state_d = S_PUSH_FLG;
        end
      end

      S_RD_HI: begin
        o_stall    = 1'b1;
        o_mem_req  = 1'b1;
        o_mem_we   = 1'b0;
        o_mem_addr = VEC_ADDR;
        if (i_mem_ack) begin
          vec_hi_d = i_mem_rdata;
          state_d  = S_RD_LO;
        end else begin
          state_d  = S_RD_HI;
        end
      end

      S_RD_LO: begin
        o_stall    = 1'b1;
        o_mem_req  = 1'b1;
        o_mem_we   = 1'b0;
        o_mem_addr = VEC_ADDR_LO;
        if (i_mem_ack) begin
          vec_lo_d = i_mem_rdata;
          state_d  = S_LOAD;
        end else begin
          state_d  = S_RD_LO;
        end
      end

      S_LOAD: begin
        // sp_q has already been decremented three times here.
        o_stall     = 1'b1;
        o_pc_load   = 1'b1;
        o_sp_wr     = 1'b1;
        o_flags_clr = 1'b1;
        o_pc_value  = {vec_hi_q, vec_lo_q};
        o_sp_next   = sp_q;
        state_d     = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_int_seq.sv
// -----------------------------------------------------------------------------
// tb_int_seq -- self-checking bench for int_seq
//
// A memory responder acks each request after a configurable (or random) number
// of wait cycles and logs every accepted transfer. Expected transfers, handler
// address, final SP, latency and stall length are computed from the stack/
// vector rules with plain arithmetic.
// -----------------------------------------------------------------------------
module tb_int_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_int;
  logic [31:0] i_pc;
  logic [2:0]  i_flags;
  logic [31:0] i_sp;
  logic        o_mem_req;
  logic        o_mem_we;
  logic [31:0] o_mem_addr;
  logic [15:0] o_mem_wdata;
  logic [15:0] i_mem_rdata;
  logic        i_mem_ack;
  logic        o_stall;
  logic        o_sp_wr;
  logic [31:0] o_sp_next;
  logic        o_pc_load;
  logic [31:0] o_pc_value;
  logic        o_flags_clr;

  int_seq dut (
    .clk         (clk),
    .rst         (rst),
    .i_int       (i_int),
    .i_pc        (i_pc),
    .i_flags     (i_flags),
    .i_sp        (i_sp),
    .o_mem_req   (o_mem_req),
    .o_mem_we    (o_mem_we),
    .o_mem_addr  (o_mem_addr),
    .o_mem_wdata (o_mem_wdata),
    .i_mem_rdata (i_mem_rdata),
    .i_mem_ack   (i_mem_ack),
    .o_stall     (o_stall),
    .o_sp_wr     (o_sp_wr),
    .o_sp_next   (o_sp_next),
    .o_pc_load   (o_pc_load),
    .o_pc_value  (o_pc_value),
    .o_flags_clr (o_flags_clr)
  );

  always #5 clk = ~clk;

  logic [117:0] all_outs;
  assign all_outs = {o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_stall,
                     o_sp_wr, o_sp_next, o_pc_load, o_pc_value, o_flags_clr};

  typedef struct { logic we; logic [31:0] addr; logic [15:0] data; } tx_t;
  typedef struct { int cyc; logic [31:0] val; logic [31:0] spn; } ld_t;

  tx_t txq[$];
  ld_t ldq[$];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int stall_cnt = 0;
  int req_cnt = 0;
  int viol = 0;
  int unstable = 0;
  int fixed_wait = 0;
  bit rand_wait = 1'b0;
  logic [15:0] vec_hi = 16'h0000;
  logic [15:0] vec_lo = 16'h0000;

  int wcnt = 0;
  int cur_wait = 0;
  logic        hold_we;
  logic [31:0] hold_addr;
  logic [15:0] hold_wdata;

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor and memory responder, both acting at the falling edge.
  always @(negedge clk) begin
    if (o_stall) stall_cnt++;
    if (o_mem_req) req_cnt++;
    if (o_pc_load) ldq.push_back('{cyc, o_pc_value, o_sp_next});
    if (o_sp_wr !== o_pc_load || o_flags_clr !== o_pc_load) viol++;
    if (o_pc_load && (!o_stall || o_mem_req || o_mem_we || o_mem_addr != 32'h0 || o_mem_wdata != 16'h0)) viol++;
    if (!o_pc_load && (o_pc_value != 32'h0 || o_sp_next != 32'h0)) viol++;
    if (!o_stall && (o_mem_req || o_mem_we || o_mem_addr != 32'h0 || o_mem_wdata != 16'h0)) viol++;

    if (rst || !o_mem_req) begin
      i_mem_ack   = 1'b0;
      i_mem_rdata = 16'($urandom);
      wcnt        = 0;
    end else begin
      if (wcnt == 0) begin
        cur_wait   = rand_wait ? int'($urandom_range(0, 3)) : fixed_wait;
        hold_we    = o_mem_we;
        hold_addr  = o_mem_addr;
        hold_wdata = o_mem_wdata;
      end else if (o_mem_we !== hold_we || o_mem_addr !== hold_addr || o_mem_wdata !== hold_wdata) begin
        unstable++;
      end
      if (wcnt == cur_wait) begin
        i_mem_ack = 1'b1;
        if (o_mem_we) i_mem_rdata = 16'($urandom);
        else if (o_mem_addr == 32'h2) i_mem_rdata = vec_hi;
        else if (o_mem_addr == 32'h3) i_mem_rdata = vec_lo;
        else i_mem_rdata = 16'($urandom);
        txq.push_back('{o_mem_we, o_mem_addr, o_mem_we ? o_mem_wdata : 16'h0});
        wcnt = 0;
      end else begin
        i_mem_ack   = 1'b0;
        i_mem_rdata = 16'($urandom);
        wcnt++;
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_logs();
    txq.delete();
    ldq.delete();
    stall_cnt = 0;
    req_cnt   = 0;
    unstable  = 0;
    viol      = 0;
  endtask

  // One full interrupt sequence, checked against the stack/vector rules.
  task automatic run_seq(input logic [31:0] sp, input logic [31:0] pc, input logic [2:0] flg,
                         input int w, input bit rnd, input string nm);
    int t0;
    int k;
    tx_t exp_tx[5];
    @(negedge clk);
    clear_logs();
    fixed_wait = w;
    rand_wait  = rnd;
    vec_hi = 16'($urandom);
    vec_lo = 16'($urandom);
    if (nm == "basic" || nm == "wait") begin
      vec_hi = 16'h00AB;
      vec_lo = 16'hCDEF;
    end
    exp_tx[0] = '{1'b1, sp,           pc[31:16]};
    exp_tx[1] = '{1'b1, sp - 32'd1,   pc[15:0]};
    exp_tx[2] = '{1'b1, sp - 32'd2,   {13'b0, flg}};
    exp_tx[3] = '{1'b0, 32'h0000_0002, 16'h0};
    exp_tx[4] = '{1'b0, 32'h0000_0003, 16'h0};
    i_sp = sp; i_pc = pc; i_flags = flg; i_int = 1'b1;
    t0 = cyc;
    @(negedge clk);
    // Inputs are only meaningful at the trigger; scramble them afterwards.
    i_int = 1'b0; i_pc = $urandom; i_sp = $urandom; i_flags = 3'($urandom);
    k = 0;
    while (ldq.size() == 0 && k < 300) begin @(negedge clk); k++; end
    repeat (3) @(negedge clk);
    checks++;
    if (ldq.size() != 1) begin
      errors++;
      $display("FAIL %s load_count: got %0d expected 1", nm, ldq.size());
    end
    checks++;
    if (txq.size() != 5) begin
      errors++;
      $display("FAIL %s mem_tx_count: got %0d expected 5", nm, txq.size());
    end
    for (int i = 0; i < 5; i++) begin
      if (i < txq.size()) begin
        checks++;
        if (txq[i].we !== exp_tx[i].we || txq[i].addr !== exp_tx[i].addr || txq[i].data !== exp_tx[i].data) begin
          errors++;
          $display("FAIL %s mem_tx%0d: got we=%0b addr=%h data=%h expected we=%0b addr=%h data=%h", nm, i,
                   txq[i].we, txq[i].addr, txq[i].data, exp_tx[i].we, exp_tx[i].addr, exp_tx[i].data);
        end
      end
    end
    if (ldq.size() > 0) begin
      checks++;
      if (ldq[0].val !== {vec_hi, vec_lo}) begin
        errors++;
        $display("FAIL %s pc_value: got %h expected %h", nm, ldq[0].val, {vec_hi, vec_lo});
      end
      checks++;
      if (ldq[0].spn !== sp - 32'd3) begin
        errors++;
        $display("FAIL %s sp_next: got %h expected %h", nm, ldq[0].spn, sp - 32'd3);
      end
      if (!rnd) begin
        // Trigger cycle, then five memory states of (w+1) cycles, then LOAD.
        checks++;
        if (ldq[0].cyc - t0 != 5 * (w + 1) + 1) begin
          errors++;
          $display("FAIL %s latency: got %0d expected %0d", nm, ldq[0].cyc - t0, 5 * (w + 1) + 1);
        end
      end
    end
    checks++;
    if (stall_cnt != (rnd ? req_cnt + 1 : 5 * (w + 1) + 1)) begin
      errors++;
      $display("FAIL %s stall_len: got %0d expected %0d", nm, stall_cnt, rnd ? req_cnt + 1 : 5 * (w + 1) + 1);
    end
    checks++;
    if (viol != 0 || unstable != 0) begin
      errors++;
      $display("FAIL %s output_rules: got viol=%0d unstable=%0d expected 0 0", nm, viol, unstable);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; i_int = 1'b0; i_pc = 32'h0; i_sp = 32'h0; i_flags = 3'b000;
    i_mem_ack = 1'b0; i_mem_rdata = 16'h0;
    repeat (3) @(negedge clk);
    checks++;
    if (all_outs !== 118'h0) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected 0", all_outs);
    end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (o_stall !== 1'b0 || o_mem_req !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: got stall=%0b req=%0b expected 0 0", o_stall, o_mem_req);
    end
  endtask

  task automatic test_basic();
    run_seq(32'h0000_07FF, 32'h0001_2345, 3'b101, 0, 1'b0, "basic");
  endtask

  task automatic test_wait_states();
    run_seq(32'h0000_07FF, 32'h0001_2345, 3'b101, 2, 1'b0, "wait");
  endtask

  task automatic test_sp_wrap();
    run_seq(32'h0000_0001, $urandom, 3'($urandom), 0, 1'b0, "sp_wrap");
  endtask

  task automatic test_random();
    for (int n = 0; n < 8; n++)
      run_seq($urandom, $urandom, 3'($urandom), 0, 1'b1, "random");
  endtask

  task automatic test_back_to_back();
    run_seq(32'h0000_1000, 32'hDEAD_BEEF, 3'b011, 1, 1'b0, "b2b_first");
    run_seq(32'h0000_0FFD, 32'hCAFE_F00D, 3'b110, 1, 1'b0, "b2b_second");
  endtask

  task automatic test_level_hold();
    @(negedge clk);
    clear_logs();
    fixed_wait = 0; rand_wait = 1'b0;
    vec_hi = 16'h1234; vec_lo = 16'h5678;
    i_sp = 32'h0000_0400; i_pc = 32'h0000_0100; i_flags = 3'b001; i_int = 1'b1;
    repeat (20) @(negedge clk);
    checks++;
    if (ldq.size() != 1) begin
      errors++;
      $display("FAIL level_hold_single: got %0d loads expected 1", ldq.size());
    end
    i_int = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (ldq.size() != 1 || o_stall !== 1'b0) begin
      errors++;
      $display("FAIL level_hold_after_drop: got loads=%0d stall=%0b expected 1 0", ldq.size(), o_stall);
    end
    i_int = 1'b1;
    repeat (12) @(negedge clk);
    i_int = 1'b0;
    checks++;
    if (ldq.size() != 2) begin
      errors++;
      $display("FAIL level_hold_rearm: got %0d loads expected 2", ldq.size());
    end else if (ldq[1].val !== 32'h1234_5678 || ldq[1].spn !== 32'h0000_03FD) begin
      errors++;
      $display("FAIL level_hold_rearm_vals: got pc=%h sp=%h expected 12345678 000003fd", ldq[1].val, ldq[1].spn);
    end
  endtask

  task automatic test_reset_mid();
    int k;
    @(negedge clk);
    clear_logs();
    fixed_wait = 1; rand_wait = 1'b0;
    i_sp = 32'h0000_0200; i_pc = 32'h0BAD_F00D; i_flags = 3'b111; i_int = 1'b1;
    @(negedge clk);
    i_int = 1'b0;
    k = 0;
    while (!(o_mem_req && o_mem_we && o_mem_addr == 32'h0000_01FF) && k < 50) begin @(negedge clk); k++; end
    checks++;
    if (k >= 50) begin
      errors++;
      $display("FAIL reset_mid_reach_push_lo: got timeout expected PUSH_LO request");
    end
    rst = 1'b1;
    #1;
    checks++;
    if (all_outs !== 118'h0) begin
      errors++;
      $display("FAIL reset_mid_outputs: got %h expected 0", all_outs);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    checks++;
    if (ldq.size() != 0 || o_stall !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_no_load: got loads=%0d stall=%0b expected 0 0", ldq.size(), o_stall);
    end
    run_seq(32'h0000_0300, 32'h7777_8888, 3'b010, 0, 1'b0, "after_reset");
  endtask

  task automatic test_edge_busy();
    int k;
    @(negedge clk);
    clear_logs();
    fixed_wait = 3; rand_wait = 1'b0;
    i_sp = 32'h0000_0500; i_pc = 32'h0000_4444; i_flags = 3'b100; i_int = 1'b1;
    @(negedge clk);
    i_int = 1'b0;
    k = 0;
    while (!(o_mem_req && !o_mem_we && o_mem_addr == 32'h2) && k < 100) begin @(negedge clk); k++; end
    i_int = 1'b1;
    @(negedge clk);
    i_int = 1'b0;
    k = 0;
    while (o_stall && k < 100) begin @(negedge clk); k++; end
    repeat (10) @(negedge clk);
    checks++;
    if (ldq.size() != 1 || txq.size() != 5 || stall_cnt != 21) begin
      errors++;
      $display("FAIL edge_busy: got loads=%0d tx=%0d stall=%0d expected 1 5 21", ldq.size(), txq.size(), stall_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wait_states();
    test_sp_wrap();
    test_level_hold();
    test_reset_mid();
    test_edge_busy();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
